matmul_output_collector_os: RTL and testbench

Parametrised output-collection controller for the output-stationary systolic matmul with recompute units (RUs). It captures staggered per-column outputs from the array bottom edge into a ROWS×COLS result buffer and substitutes RU results for faulty PEs. It tracks per-cell completion, so ready is declared only when every cell is filled, whatever the fault pattern. A start/ack handshake delimits each tile, and protocol violations are flagged.

---
 rtl/matmul_os_pkg.sv | 11 +
 rtl/osc_col_tracker.sv | 34 +++
 rtl/matmul_output_collector_os.sv | 129 ++++++++++++
 tb/tb_matmul_output_collector_os.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/matmul_os_pkg.sv
// Shared types and helpers for the output-stationary matmul output collector.
package matmul_os_pkg;

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   // Flat cell index of (r,c) in a row-major ROWS x cols buffer.
   function automatic int idx(input int r, input int c, input int cols);
      return r * cols + c;
   endfunction

endpackage

// File: rtl/osc_col_tracker.sv
// Per-column arrival counter: maps the k-th valid of a column to row ROWS-1-k.
module osc_col_tracker #(
   parameter int ROWS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   input  logic                     en,
   input  logic                     valid,
   input  logic [ROWS-1:0]          ok,
   output logic [$clog2(ROWS)-1:0]  row,
   output logic                     we,
   output logic                     ovf
);
   localparam int RB = $clog2(ROWS);
   localparam int NB = $clog2(ROWS + 1);

   logic [NB-1:0] cnt;
   logic          in_range;

   assign in_range = (cnt < NB'(ROWS));
   assign row      = in_range ? RB'(ROWS - 1 - int'(cnt)) : '0;
   // Faulty cells still consume an arrival slot; only the write is suppressed.
   assign we       = en & valid & in_range & ok[row];
   assign ovf      = en & valid & ~in_range;

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && valid && in_range)
         cnt <= cnt + NB'(1);
   end

endmodule

// File: rtl/matmul_output_collector_os.sv
// Collects staggered bottom-edge outputs into a ROWS x COLS buffer, with RU override.
module matmul_output_collector_os
   import matmul_os_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int WORD_SIZE = 16,
   parameter int NUM_RU    = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [ROWS*COLS-1:0]                pe_ok_mat,
   input  logic [COLS*WORD_SIZE-1:0]           array_out,
   input  logic [COLS-1:0]                     array_out_valid,
   input  logic [NUM_RU-1:0]                   ru_valid,
   input  logic [NUM_RU*WORD_SIZE-1:0]         ru_out,
   input  logic [NUM_RU*$clog2(ROWS)-1:0]      ru_row_map,
   input  logic [NUM_RU*$clog2(COLS)-1:0]      ru_col_map,
   input  logic                                matrix_ack,
   output logic [ROWS*COLS*WORD_SIZE-1:0]      output_matrix,
   output logic                                matrix_rdy,
   output logic                                err
);
   localparam int RB = $clog2(ROWS);
   localparam int CB = $clog2(COLS);
   localparam int NC = ROWS * COLS;

   state_t                          state;
   logic [NC-1:0][WORD_SIZE-1:0]    mat_q, wr_data;
   logic [NC-1:0]                   fill_q, ok_q, wr_en, fill_next;
   logic [COLS-1:0][ROWS-1:0]       ok_col;
   logic [COLS-1:0][RB-1:0]         arr_row;
   logic [COLS-1:0]                 arr_we, arr_ovf;
   logic                            active, ru_bad, stray, err_set;

   // Valids in a start cycle belong to no tile and are dropped silently.
   assign active = (state == COLLECT) && !start;

   genvar gc, gr;
   generate
      for (gc = 0; gc < COLS; gc++) begin : g_col
         for (gr = 0; gr < ROWS; gr++) begin : g_ok
            assign ok_col[gc][gr] = ok_q[idx(gr, gc, COLS)];
         end
         osc_col_tracker #(.ROWS(ROWS)) u_trk (
            .clk   (clk),
            .rst   (rst),
            .clr   (start),
            .en    (active),
            .valid (array_out_valid[gc]),
            .ok    (ok_col[gc]),
            .row   (arr_row[gc]),
            .we    (arr_we[gc]),
            .ovf   (arr_ovf[gc])
         );
      end
   endgenerate

   // Array writes first, then RUs in ascending order so the highest RU wins a cell.
   always_comb begin
      int rr, cc;
      wr_en   = '0;
      wr_data = '0;
      ru_bad  = 1'b0;
      rr      = 0;
      cc      = 0;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            if (arr_we[c] && int'(arr_row[c]) == r) begin
               wr_en[idx(r, c, COLS)]   = 1'b1;
               wr_data[idx(r, c, COLS)] = array_out[c*WORD_SIZE +: WORD_SIZE];
            end
      for (int i = 0; i < NUM_RU; i++)
         if (active && ru_valid[i]) begin
            rr = int'(ru_row_map[i*RB +: RB]);
            cc = int'(ru_col_map[i*CB +: CB]);
            if (rr >= ROWS || cc >= COLS)
               ru_bad = 1'b1;
            else begin
               wr_en[idx(rr, cc, COLS)]   = 1'b1;
               wr_data[idx(rr, cc, COLS)] = ru_out[i*WORD_SIZE +: WORD_SIZE];
            end
         end
   end

   assign stray     = (state != COLLECT) && !start && ((|array_out_valid) || (|ru_valid));
   assign err_set   = (|arr_ovf) | ru_bad | stray;
   assign fill_next = fill_q | wr_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mat_q      <= '0;
         fill_q     <= '0;
         ok_q       <= '0;
         matrix_rdy <= 1'b0;
         err        <= 1'b0;
      end else if (start) begin
         state      <= COLLECT;
         mat_q      <= '0;
         fill_q     <= '0;
         ok_q       <= pe_ok_mat;
         matrix_rdy <= 1'b0;
         err        <= 1'b0;
      end else begin
         err <= err | err_set;
         case (state)
            COLLECT: begin
               for (int k = 0; k < NC; k++)
                  if (wr_en[k]) mat_q[k] <= wr_data[k];
               fill_q <= fill_next;
               if (&fill_next) begin
                  state      <= DONE;
                  matrix_rdy <= 1'b1;
               end
            end
            DONE: if (matrix_ack) begin
               state      <= IDLE;
               matrix_rdy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign output_matrix = mat_q;

endmodule

// File: tb/tb_matmul_output_collector_os.sv
// Directed bench: a 4x4 collector and a 3x5 collector with one faulty PE.
module tb_matmul_output_collector_os;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // 4x4 instance
   logic         a_start, a_ack, a_rdy, a_err;
   logic [15:0]  a_ok;
   logic [63:0]  a_ao, a_ruo;
   logic [3:0]   a_aov, a_ruv;
   logic [7:0]   a_rr, a_rc;
   logic [255:0] a_om, exp_a;

   // 3x5 instance
   logic         b_start, b_ack, b_rdy, b_err;
   logic [14:0]  b_ok;
   logic [79:0]  b_ao;
   logic [4:0]   b_aov;
   logic [3:0]   b_ruv;
   logic [63:0]  b_ruo;
   logic [7:0]   b_rr;
   logic [11:0]  b_rc;
   logic [239:0] b_om, exp_b;

   matmul_output_collector_os #(.ROWS(4), .COLS(4), .WORD_SIZE(16), .NUM_RU(4)) u_a (
      .clk(clk), .rst(rst), .start(a_start), .pe_ok_mat(a_ok), .array_out(a_ao),
      .array_out_valid(a_aov), .ru_valid(a_ruv), .ru_out(a_ruo), .ru_row_map(a_rr),
      .ru_col_map(a_rc), .matrix_ack(a_ack), .output_matrix(a_om), .matrix_rdy(a_rdy),
      .err(a_err));

   matmul_output_collector_os #(.ROWS(3), .COLS(5), .WORD_SIZE(16), .NUM_RU(4)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .pe_ok_mat(b_ok), .array_out(b_ao),
      .array_out_valid(b_aov), .ru_valid(b_ruv), .ru_out(b_ruo), .ru_row_map(b_rr),
      .ru_col_map(b_rc), .matrix_ack(b_ack), .output_matrix(b_om), .matrix_rdy(b_rdy),
      .err(b_err));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] acell(input int r, input int c);
      return a_om[(r*4+c)*16 +: 16];
   endfunction

   function automatic logic [15:0] bcell(input int r, input int c);
      return b_om[(r*5+c)*16 +: 16];
   endfunction

   // Column c fires on cycles c..c+3; the k-th arrival lands on row 3-k with 16*row+c.
   task automatic run_full_a;
      a_start = 1'b1; tick; a_start = 1'b0;
      for (int t = 0; t < 7; t++) begin
         a_aov = '0;
         for (int c = 0; c < 4; c++)
            if (t >= c && t <= c + 3) begin
               a_aov[c] = 1'b1;
               a_ao[c*16 +: 16] = 16'(16 * (3 - (t - c)) + c);
            end
         tick;
         if (t == 5) chk("a_rdy_early", a_rdy, 0);
         if (t == 6) chk("a_rdy_last", a_rdy, 1);
      end
      a_aov = '0;
   endtask

   initial begin
      rst = 1'b1;
      a_start = 0; a_ack = 0; a_ok = '1; a_ao = '0; a_aov = '0; a_ruv = '0; a_ruo = '0; a_rr = '0; a_rc = '0;
      b_start = 0; b_ack = 0; b_ok = '1; b_ao = '0; b_aov = '0; b_ruv = '0; b_ruo = '0; b_rr = '0; b_rc = '0;
      tick; tick;
      rst = 1'b0;
      chk("rst_a_om", a_om, 0);
      chk("rst_a_rdy", a_rdy, 0);
      chk("rst_a_err", a_err, 0);
      chk("rst_b_om", b_om, 0);
      chk("rst_b_rdy", b_rdy, 0);

      exp_a = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            exp_a[(r*4+c)*16 +: 16] = 16'(16 * r + c);

      run_full_a;
      chk("a_full_om", a_om, exp_a);
      chk("a_full_err", a_err, 0);

      for (int i = 0; i < 10; i++) begin
         tick;
         chk("a_hold_rdy", a_rdy, 1);
         chk("a_hold_om", a_om, exp_a);
      end

      a_ack = 1'b1; a_start = 1'b1; tick; a_ack = 1'b0; a_start = 1'b0;
      chk("a_ackstart_rdy", a_rdy, 0);
      chk("a_ackstart_om", a_om, 0);

      // Three arrivals on column 0 fill rows 3,2,1; the fourth collides with RU1/RU2 on (0,0).
      a_aov = 4'b0001;
      for (int j = 0; j < 3; j++) begin
         a_ao[15:0] = 16'(16 * (3 - j));
         tick;
      end
      a_ao[15:0] = 16'hAAAA;
      a_ruv = 4'b0110;
      a_ruo[16 +: 16] = 16'h1111;
      a_ruo[32 +: 16] = 16'h2222;
      tick;
      a_ruv = '0;
      chk("prio_cell00", acell(0, 0), 16'h2222);
      chk("prio_cell10", acell(1, 0), 16'h0010);
      chk("prio_err", a_err, 0);

      a_ao[15:0] = 16'h5555;
      tick;
      a_aov = '0;
      chk("ovf_err", a_err, 1);
      chk("ovf_cell00", acell(0, 0), 16'h2222);
      chk("ovf_cell30", acell(3, 0), 16'h0030);

      a_start = 1'b1; tick; a_start = 1'b0;
      chk("restart_err", a_err, 0);
      chk("restart_om", a_om, 0);

      // 3x5 with PE(1,2) faulty; RU0 repairs it two cycles after the array finishes.
      b_ok = 15'h7FFF & ~(15'h0001 << 7);
      exp_b = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 5; c++)
            exp_b[(r*5+c)*16 +: 16] = 16'(16'h100 + 16 * r + c);
      exp_b[(1*5+2)*16 +: 16] = 16'hBEEF;
      b_start = 1'b1; tick; b_start = 1'b0;
      for (int t = 0; t < 3; t++) begin
         b_aov = 5'h1F;
         for (int c = 0; c < 5; c++) b_ao[c*16 +: 16] = 16'(16'h100 + 16 * (2 - t) + c);
         tick;
      end
      b_aov = '0;
      chk("b_rdy_hole", b_rdy, 0);
      chk("b_cell12_hole", bcell(1, 2), 0);

      b_ruv = 4'b1100;
      b_rr[6 +: 2] = 2'd3; b_rc[9 +: 3] = 3'd0; b_ruo[48 +: 16] = 16'h1234;
      b_rr[4 +: 2] = 2'd0; b_rc[6 +: 3] = 3'd6; b_ruo[32 +: 16] = 16'h5678;
      tick;
      b_ruv = '0;
      chk("b_range_err", b_err, 1);
      chk("b_range_rdy", b_rdy, 0);
      chk("b_range_cell00", bcell(0, 0), 16'h0100);

      b_ruv = 4'b0001;
      b_rr[0 +: 2] = 2'd1; b_rc[0 +: 3] = 3'd2; b_ruo[0 +: 16] = 16'hBEEF;
      tick;
      b_ruv = '0;
      chk("b_ru_rdy", b_rdy, 1);
      chk("b_ru_om", b_om, exp_b);

      b_ack = 1'b1; tick; b_ack = 1'b0;
      chk("b_ack_rdy", b_rdy, 0);

      // Mid-tile reset on the 4x4 (already collecting after the last restart).
      a_aov = 4'b0001;
      a_ao[15:0] = 16'h0030; tick;
      a_ao[15:0] = 16'h0020; tick;
      a_aov = '0;
      chk("mid_cell30", acell(3, 0), 16'h0030);
      rst = 1'b1; tick; rst = 1'b0;
      chk("mid_rst_om", a_om, 0);
      chk("mid_rst_rdy", a_rdy, 0);
      chk("mid_rst_err", a_err, 0);

      run_full_a;
      chk("fresh_om", a_om, exp_a);
      a_ack = 1'b1; tick; a_ack = 1'b0;
      chk("fresh_ack_rdy", a_rdy, 0);
      a_aov = 4'b0100; tick; a_aov = '0;
      chk("idle_stray_err", a_err, 1);
      chk("idle_stray_om", a_om, exp_a);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
